mem_wb_writeback: RTL and testbench

Write-back stage consuming the MEM/WB pipeline register outputs. Selects the write-back value from the ALU result, the load word or byte, or the link address, and drives the register-file write port through a one-cycle output register. Also exposes a bypass copy of the last committed write for forwarding, counts committed writes, and sequences processor halt through a drain FSM. Sits between the MEM/WB register and the register file / hazard unit.

---
 rtl/mem_wb_writeback_pkg.sv | 16 +
 rtl/mem_wb_writeback_wb_value_mux.sv | 33 +++
 rtl/mem_wb_writeback.sv | 110 +++++++++++
 tb/tb_mem_wb_writeback.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_writeback_pkg.sv
// Shared types and constants for the write-back stage: FSM states,
// the link jump code and the byte-lane view of load data.
package mem_wb_writeback_pkg;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } wb_state_t;

    localparam logic [1:0] JUMP_LINK = 2'b10;

    // Lane [0] is the most significant byte of the load word.
    typedef logic [0:3][7:0] byte_lanes_t;

endpackage

// File: rtl/mem_wb_writeback_wb_value_mux.sv
// Combinational write-back value select: link address, sign-extended
// load byte, full load word or ALU result, in that priority.
module wb_value_mux
    import mem_wb_writeback_pkg::*;
#(
    parameter logic [31:0] LINK_OFFSET = 32'd4
) (
    input  logic [1:0]  jump,
    input  logic        mem_to_reg,
    input  logic        is_LB_SB,
    input  byte_lanes_t cache_data_out,
    input  logic [1:0]  mem_block,
    input  logic [31:0] pc,
    input  logic [31:0] alu_result,
    output logic [31:0] wb_value
);

    logic [7:0] load_byte;

    assign load_byte = cache_data_out[mem_block];

    always_comb begin
        wb_value = alu_result;
        if (jump == JUMP_LINK) begin
            wb_value = pc + LINK_OFFSET;
        end else if (mem_to_reg && is_LB_SB) begin
            wb_value = {{24{load_byte[7]}}, load_byte};
        end else if (mem_to_reg) begin
            wb_value = cache_data_out;
        end
    end

endmodule

// File: rtl/mem_wb_writeback.sv
// Write-back stage: registered register-file write port, forwarding copy
// of the last commit, commit counter and the halt drain sequencer.
module mem_wb_writeback
    import mem_wb_writeback_pkg::*;
#(
    parameter int          DRAIN_CYCLES = 4,
    parameter logic [31:0] LINK_OFFSET  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        is_LB_SB,
    input  byte_lanes_t cache_data_out,
    input  logic [1:0]  mem_block,
    input  logic        mem_to_reg,
    input  logic [1:0]  jump,
    input  logic [31:0] pc,
    input  logic [31:0] alu_result,
    input  logic [4:0]  dest_reg_num,
    input  logic        reg_write,
    input  logic        halted,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        fwd_valid,
    output logic [4:0]  fwd_reg,
    output logic [31:0] fwd_data,
    output logic [31:0] write_count,
    output logic        halt_out
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    wb_state_t        state, next_state;
    logic [CNT_W-1:0] drain_cnt, next_cnt;
    logic             commit;
    logic [31:0]      wb_value;

    wb_value_mux #(
        .LINK_OFFSET(LINK_OFFSET)
    ) u_value_mux (
        .jump          (jump),
        .mem_to_reg    (mem_to_reg),
        .is_LB_SB      (is_LB_SB),
        .cache_data_out(cache_data_out),
        .mem_block     (mem_block),
        .pc            (pc),
        .alu_result    (alu_result),
        .wb_value      (wb_value)
    );

    // Only RUN accepts writes; a halt seen in RUN still lets its own write commit.
    always_comb begin
        next_state = state;
        next_cnt   = drain_cnt;
        commit     = 1'b0;
        case (state)
            RUN: begin
                commit = !freeze && reg_write && (dest_reg_num != 5'd0);
                if (halted && !freeze) begin
                    next_state = DRAIN;
                    next_cnt   = CNT_W'(DRAIN_CYCLES - 1);
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    next_state = HALTED;
                end else begin
                    next_cnt = drain_cnt - CNT_W'(1);
                end
            end
            HALTED: begin
                next_state = HALTED;
            end
            default: begin
                next_state = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            drain_cnt   <= '0;
            rf_we       <= 1'b0;
            rf_waddr    <= 5'd0;
            rf_wdata    <= 32'd0;
            fwd_valid   <= 1'b0;
            fwd_reg     <= 5'd0;
            fwd_data    <= 32'd0;
            write_count <= 32'd0;
            halt_out    <= 1'b0;
        end else begin
            state     <= next_state;
            drain_cnt <= next_cnt;
            rf_we     <= commit;
            // halt_out trails HALTED by one edge so it lands DRAIN_CYCLES+1 edges after the halt.
            halt_out  <= (state == HALTED);
            if (commit) begin
                rf_waddr    <= dest_reg_num;
                rf_wdata    <= wb_value;
                fwd_valid   <= 1'b1;
                fwd_reg     <= dest_reg_num;
                fwd_data    <= wb_value;
                write_count <= write_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Self-checking bench for mem_wb_writeback: a queue of expected writes is
// filled as stimulus is applied and drained as rf_we pulses appear.
module tb_mem_wb_writeback;
    import mem_wb_writeback_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        is_LB_SB;
    byte_lanes_t cache_data_out;
    logic [1:0]  mem_block;
    logic        mem_to_reg;
    logic [1:0]  jump;
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [4:0]  dest_reg_num;
    logic        reg_write;
    logic        halted;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
    logic [31:0] write_count;
    logic        halt_out;

    int          n_compared   = 0;
    int          n_mismatched = 0;
    logic [36:0] exp_q[$];
    logic [36:0] exp_w;
    logic [36:0] last_w;
    logic [31:0] exp_count;

    mem_wb_writeback #(
        .DRAIN_CYCLES(4),
        .LINK_OFFSET (32'd4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .freeze        (freeze),
        .is_LB_SB      (is_LB_SB),
        .cache_data_out(cache_data_out),
        .mem_block     (mem_block),
        .mem_to_reg    (mem_to_reg),
        .jump          (jump),
        .pc            (pc),
        .alu_result    (alu_result),
        .dest_reg_num  (dest_reg_num),
        .reg_write     (reg_write),
        .halted        (halted),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .fwd_valid     (fwd_valid),
        .fwd_reg       (fwd_reg),
        .fwd_data      (fwd_data),
        .write_count   (write_count),
        .halt_out      (halt_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        rst            = 1'b0;
        freeze         = 1'b0;
        is_LB_SB       = 1'b0;
        cache_data_out = '0;
        mem_block      = 2'd0;
        mem_to_reg     = 1'b0;
        jump           = 2'b00;
        pc             = 32'd0;
        alu_result     = 32'd0;
        dest_reg_num   = 5'd0;
        reg_write      = 1'b0;
        halted         = 1'b0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] val);
        drive_idle();
        reg_write    = 1'b1;
        dest_reg_num = rd;
        alu_result   = val;
    endtask

    task automatic test_reset();
        drive_alu(5'd7, 32'hDEADBEEF);
        halted = 1'b1;
        rst    = 1'b1;
        tick();
        exp_q.delete();
        exp_count = 32'd0;
        last_w    = '0;
        n_compared++;
        if ({rf_we, rf_waddr, rf_wdata} !== 38'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_rf: got %h expected 0", {rf_we, rf_waddr, rf_wdata});
        end
        n_compared++;
        if ({fwd_valid, fwd_reg, fwd_data} !== 38'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_fwd: got %h expected 0", {fwd_valid, fwd_reg, fwd_data});
        end
        n_compared++;
        if ({write_count, halt_out} !== 33'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_count_halt: got count=%h halt=%b expected 0/0", write_count, halt_out);
        end
        drive_idle();
    endtask

    task automatic test_alu_write();
        drive_alu(5'd5, 32'h12345678);
        exp_q.push_back({5'd5, 32'h12345678});
        exp_count++;
        tick();
        n_compared++;
        if (rf_we !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL alu_rf_we: got %b expected 1", rf_we);
        end
        exp_w  = exp_q.pop_front();
        last_w = exp_w;
        n_compared++;
        if ({rf_waddr, rf_wdata} !== exp_w) begin
            n_mismatched++;
            $display("[TB] FAIL alu_rf_data: got %h expected %h", {rf_waddr, rf_wdata}, exp_w);
        end
        n_compared++;
        if ({fwd_valid, fwd_reg, fwd_data} !== {1'b1, exp_w}) begin
            n_mismatched++;
            $display("[TB] FAIL alu_fwd: got %h expected %h", {fwd_valid, fwd_reg, fwd_data}, {1'b1, exp_w});
        end
        n_compared++;
        if (write_count !== exp_count) begin
            n_mismatched++;
            $display("[TB] FAIL alu_count: got %0d expected %0d", write_count, exp_count);
        end
        drive_idle();
        tick();
        n_compared++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, last_w}) begin
            n_mismatched++;
            $display("[TB] FAIL alu_hold: got %h expected %h", {rf_we, rf_waddr, rf_wdata}, {1'b0, last_w});
        end
    endtask

    // Back-to-back loads: LW, then LB lanes 2 and 3, on consecutive cycles.
    task automatic test_loads();
        logic [1:0]  blk[3]  = '{2'd0, 2'd2, 2'd3};
        logic        lb[3]   = '{1'b0, 1'b1, 1'b1};
        logic [31:0] want[3] = '{32'h11228344, 32'hFFFFFF83, 32'h00000044};
        for (int i = 0; i < 3; i++) begin
            drive_alu(5'(6 + i), 32'hA5A5A5A5);
            mem_to_reg     = 1'b1;
            is_LB_SB       = lb[i];
            mem_block      = blk[i];
            cache_data_out = '{8'h11, 8'h22, 8'h83, 8'h44};
            exp_q.push_back({5'(6 + i), want[i]});
            exp_count++;
            tick();
            n_compared++;
            if (rf_we !== 1'b1) begin
                n_mismatched++;
                $display("[TB] FAIL load%0d_rf_we: got %b expected 1", i, rf_we);
            end
            if (exp_q.size() != 0) begin
                exp_w  = exp_q.pop_front();
                last_w = exp_w;
                n_compared++;
                if ({rf_waddr, rf_wdata} !== exp_w) begin
                    n_mismatched++;
                    $display("[TB] FAIL load%0d_data: got %h expected %h", i, {rf_waddr, rf_wdata}, exp_w);
                end
            end
        end
        n_compared++;
        if (write_count !== exp_count) begin
            n_mismatched++;
            $display("[TB] FAIL load_count: got %0d expected %0d", write_count, exp_count);
        end
        drive_idle();
    endtask

    task automatic test_link_zero();
        drive_alu(5'd31, 32'h0BADF00D);
        jump       = JUMP_LINK;
        pc         = 32'h00000100;
        mem_to_reg = 1'b1;
        exp_q.push_back({5'd31, 32'h00000104});
        exp_count++;
        tick();
        exp_w  = exp_q.pop_front();
        last_w = exp_w;
        n_compared++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, exp_w}) begin
            n_mismatched++;
            $display("[TB] FAIL link_write: got %h expected %h", {rf_we, rf_waddr, rf_wdata}, {1'b1, exp_w});
        end
        drive_alu(5'd0, 32'h77777777);
        tick();
        n_compared++;
        if ({rf_we, rf_waddr, rf_wdata, write_count} !== {1'b0, last_w, exp_count}) begin
            n_mismatched++;
            $display("[TB] FAIL zero_reg: got we=%b %h cnt=%0d expected we=0 %h cnt=%0d",
                     rf_we, {rf_waddr, rf_wdata}, write_count, last_w, exp_count);
        end
        n_compared++;
        if ({fwd_reg, fwd_data} !== last_w) begin
            n_mismatched++;
            $display("[TB] FAIL zero_fwd_hold: got %h expected %h", {fwd_reg, fwd_data}, last_w);
        end
        drive_idle();
    endtask

    task automatic test_freeze();
        drive_alu(5'd12, 32'hCAFEF00D);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_compared++;
            if ({rf_we, write_count} !== {1'b0, exp_count}) begin
                n_mismatched++;
                $display("[TB] FAIL freeze%0d: got we=%b cnt=%0d expected we=0 cnt=%0d", i, rf_we, write_count, exp_count);
            end
        end
        freeze = 1'b0;
        exp_q.push_back({5'd12, 32'hCAFEF00D});
        exp_count++;
        tick();
        exp_w  = exp_q.pop_front();
        last_w = exp_w;
        n_compared++;
        if ({rf_we, rf_waddr, rf_wdata, write_count} !== {1'b1, exp_w, exp_count}) begin
            n_mismatched++;
            $display("[TB] FAIL unfreeze: got we=%b %h cnt=%0d expected we=1 %h cnt=%0d",
                     rf_we, {rf_waddr, rf_wdata}, write_count, exp_w, exp_count);
        end
        drive_idle();
        tick();
        n_compared++;
        if ({rf_we, write_count} !== {1'b0, exp_count}) begin
            n_mismatched++;
            $display("[TB] FAIL unfreeze_single: got we=%b cnt=%0d expected we=0 cnt=%0d", rf_we, write_count, exp_count);
        end
    endtask

    task automatic test_halt();
        drive_alu(5'd9, 32'h00000099);
        halted = 1'b1;
        exp_q.push_back({5'd9, 32'h00000099});
        exp_count++;
        tick();
        exp_w  = exp_q.pop_front();
        last_w = exp_w;
        n_compared++;
        if ({rf_we, rf_waddr, rf_wdata, halt_out} !== {1'b1, exp_w, 1'b0}) begin
            n_mismatched++;
            $display("[TB] FAIL halt_same_write: got we=%b %h halt=%b expected we=1 %h halt=0",
                     rf_we, {rf_waddr, rf_wdata}, halt_out, exp_w);
        end
        // Writes keep arriving during drain and halt; freeze toggles to show it is ignored.
        for (int i = 1; i <= 8; i++) begin
            drive_alu(5'(10 + i), 32'h1000 + i);
            freeze = i[0];
            tick();
            n_compared++;
            if ({halt_out, rf_we, write_count} !== {(i >= 5), 1'b0, exp_count}) begin
                n_mismatched++;
                $display("[TB] FAIL halt_edge%0d: got halt=%b we=%b cnt=%0d expected halt=%b we=0 cnt=%0d",
                         i, halt_out, rf_we, write_count, (i >= 5), exp_count);
            end
        end
        n_compared++;
        if ({rf_waddr, rf_wdata} !== last_w) begin
            n_mismatched++;
            $display("[TB] FAIL halted_hold: got %h expected %h", {rf_waddr, rf_wdata}, last_w);
        end
        drive_idle();
    endtask

    task automatic test_reset_mid_drain();
        drive_alu(5'd3, 32'h33333333);
        halted = 1'b1;
        exp_count++;
        tick();
        drive_alu(5'd4, 32'h44444444);
        tick();
        tick();
        rst    = 1'b1;
        halted = 1'b1;
        tick();
        exp_count = 32'd0;
        n_compared++;
        if ({rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_reg, fwd_data, write_count, halt_out} !== 110'd0) begin
            n_mismatched++;
            $display("[TB] FAIL drain_reset: got we=%b %h fwd=%b %h cnt=%0d halt=%b expected all 0",
                     rf_we, {rf_waddr, rf_wdata}, fwd_valid, {fwd_reg, fwd_data}, write_count, halt_out);
        end
        drive_alu(5'd4, 32'h44444444);
        exp_q.push_back({5'd4, 32'h44444444});
        exp_count++;
        tick();
        exp_w = exp_q.pop_front();
        n_compared++;
        if ({rf_we, rf_waddr, rf_wdata, write_count} !== {1'b1, exp_w, exp_count}) begin
            n_mismatched++;
            $display("[TB] FAIL run_after_reset: got we=%b %h cnt=%0d expected we=1 %h cnt=%0d",
                     rf_we, {rf_waddr, rf_wdata}, write_count, exp_w, exp_count);
        end
        drive_idle();
        repeat (6) tick();
        n_compared++;
        if (halt_out !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL no_halt_after_reset: got %b expected 0", halt_out);
        end
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL scoreboard_empty: got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        drive_idle();
        exp_count = 32'd0;
        last_w    = '0;
        test_reset();
        test_alu_write();
        test_loads();
        test_link_zero();
        test_freeze();
        test_halt();
        test_reset_mid_drain();
        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
